// File: rtl/spectrum_peak_meter_pkg.sv
// Shared constants and FSM encoding for the spectrum peak meter.
// Band count, magnitude width and band-index width are fixed for the seven-band front end.
package spectrum_peak_meter_pkg;

  localparam int NUM_BANDS  = 7;
  localparam int BAND_W     = 8;
  localparam int BAND_IDX_W = 3;

  localparam logic [BAND_IDX_W-1:0] LAST_BAND = BAND_IDX_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spectrum_peak_ram.sv
// Per-band register file holding level, held peak and hold counter.
// One synchronous write port and a combinational read port for the sweep; one registered display port.
module spectrum_peak_ram
  import spectrum_peak_meter_pkg::*;
#(
  parameter int HOLD_W = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [BAND_IDX_W-1:0] wr_band,
  input  logic [BAND_W-1:0]     wr_level,
  input  logic [BAND_W-1:0]     wr_peak,
  input  logic [HOLD_W-1:0]     wr_hold,
  input  logic [BAND_IDX_W-1:0] sw_band,
  output logic [BAND_W-1:0]     sw_peak,
  output logic [HOLD_W-1:0]     sw_hold,
  input  logic [BAND_IDX_W-1:0] rd_band,
  output logic [BAND_W-1:0]     rd_level,
  output logic [BAND_W-1:0]     rd_peak
);

  logic [BAND_W-1:0] level_q [NUM_BANDS];
  logic [BAND_W-1:0] peak_q  [NUM_BANDS];
  logic [HOLD_W-1:0] hold_q  [NUM_BANDS];

  assign sw_peak = peak_q[sw_band];
  assign sw_hold = hold_q[sw_band];

  // Display read samples the pre-write contents when the same band is being swept.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        level_q[i] <= '0;
        peak_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
      rd_level <= '0;
      rd_peak  <= '0;
    end else begin
      if (we) begin
        level_q[wr_band] <= wr_level;
        peak_q[wr_band]  <= wr_peak;
        hold_q[wr_band]  <= wr_hold;
      end
      if (rd_band < BAND_IDX_W'(NUM_BANDS)) begin
        rd_level <= level_q[rd_band];
        rd_peak  <= peak_q[rd_band];
      end else begin
        rd_level <= '0;
        rd_peak  <= '0;
      end
    end
  end

endmodule

// File: rtl/spectrum_peak_meter.sv
// Seven-band level/peak meter: latches a frame on each ready strobe and sweeps one band per cycle,
// applying peak hold and prescaled decay; one frame may wait in a pending buffer while busy.
module spectrum_peak_meter
  import spectrum_peak_meter_pkg::*;
#(
  parameter int HOLD_SAMPLES = 24000,
  parameter int HOLD_W       = 15,
  parameter int DECAY_DIV    = 480,
  parameter int DECAY_STEP   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ready,
  input  logic [BAND_W-1:0]     freq1,
  input  logic [BAND_W-1:0]     freq2,
  input  logic [BAND_W-1:0]     freq3,
  input  logic [BAND_W-1:0]     freq4,
  input  logic [BAND_W-1:0]     freq5,
  input  logic [BAND_W-1:0]     freq6,
  input  logic [BAND_W-1:0]     freq7,
  input  logic [BAND_IDX_W-1:0] rd_band,
  output logic [BAND_W-1:0]     rd_level,
  output logic [BAND_W-1:0]     rd_peak,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [1:0]            state_dbg
);

  localparam int                  PRESC_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT  = HOLD_W'(HOLD_SAMPLES);
  localparam logic [BAND_W-1:0]   STEP_V     = BAND_W'(DECAY_STEP);

  // Handshake: ready is a one-cycle strobe with no backpressure; the frame on freq1..7 is
  // valid only in that cycle and is either latched (frame/pending buffer) or dropped with overrun.
  state_t                  state, state_next;
  logic [BAND_IDX_W-1:0]   band, band_next;
  logic [BAND_W-1:0]       freq_in [NUM_BANDS];
  logic [BAND_W-1:0]       frame_q [NUM_BANDS];
  logic [BAND_W-1:0]       pend_q  [NUM_BANDS];
  logic                    frame_tick_q, pend_tick_q, pend_valid_q, overrun_q;
  logic [PRESC_W-1:0]      presc_q;
  logic                    tick_in;
  logic                    load_in, load_pend, pend_load, pend_clr, drop, we;
  logic [BAND_W-1:0]       new_mag, sw_peak, wr_peak;
  logic [HOLD_W-1:0]       sw_hold, wr_hold;

  always_comb begin
    freq_in[0] = freq1;
    freq_in[1] = freq2;
    freq_in[2] = freq3;
    freq_in[3] = freq4;
    freq_in[4] = freq5;
    freq_in[5] = freq6;
    freq_in[6] = freq7;
  end

  assign tick_in    = (presc_q == PRESC_LAST);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign overrun    = overrun_q;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    band_next  = band;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    pend_load  = 1'b0;
    pend_clr   = 1'b0;
    drop       = 1'b0;
    we         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ready) begin
          load_in    = 1'b1;
          band_next  = '0;
          state_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        we = 1'b1;
        if (band == LAST_BAND) state_next = ST_DONE;
        else                   band_next  = band + 1'b1;
        if (ready) begin
          if (pend_valid_q) drop      = 1'b1;
          else              pend_load = 1'b1;
        end
      end
      ST_DONE: begin
        band_next = '0;
        if (pend_valid_q) begin
          load_pend  = 1'b1;
          pend_clr   = 1'b1;
          state_next = ST_SWEEP;
          drop       = ready;
        end else if (ready) begin
          // Slot is free and the engine is about to be free: start this frame directly.
          load_in    = 1'b1;
          state_next = ST_SWEEP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      band         <= '0;
      presc_q      <= '0;
      frame_tick_q <= 1'b0;
      pend_tick_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        frame_q[i] <= '0;
        pend_q[i]  <= '0;
      end
    end else begin
      state <= state_next;
      band  <= band_next;
      if (ready) presc_q <= tick_in ? '0 : presc_q + 1'b1;
      if (load_in) begin
        frame_q      <= freq_in;
        frame_tick_q <= tick_in;
      end else if (load_pend) begin
        frame_q      <= pend_q;
        frame_tick_q <= pend_tick_q;
      end
      if (pend_load) begin
        pend_q       <= freq_in;
        pend_tick_q  <= tick_in;
        pend_valid_q <= 1'b1;
      end else if (pend_clr) begin
        pend_valid_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  // A new maximum (including equal) re-arms the hold; decay only starts once hold has run out.
  always_comb begin
    new_mag = frame_q[band];
    wr_peak = sw_peak;
    wr_hold = sw_hold;
    if (new_mag >= sw_peak) begin
      wr_peak = new_mag;
      wr_hold = HOLD_INIT;
    end else if (sw_hold != '0) begin
      wr_hold = sw_hold - 1'b1;
    end else if (frame_tick_q) begin
      wr_peak = (sw_peak > STEP_V) ? sw_peak - STEP_V : '0;
    end
  end

  spectrum_peak_ram #(
    .HOLD_W (HOLD_W)
  ) u_ram (
    .clock    (clock),
    .reset    (reset),
    .we       (we),
    .wr_band  (band),
    .wr_level (new_mag),
    .wr_peak  (wr_peak),
    .wr_hold  (wr_hold),
    .sw_band  (band),
    .sw_peak  (sw_peak),
    .sw_hold  (sw_hold),
    .rd_band  (rd_band),
    .rd_level (rd_level),
    .rd_peak  (rd_peak)
  );

endmodule

// File: tb/tb_spectrum_peak_meter.sv
// Bench for spectrum_peak_meter: frame-schedule reference model checked every cycle,
// a constant read table, hand-written corner sequences and randomized traffic.
module tb_spectrum_peak_meter;

  localparam int HOLD_SAMPLES = 4;
  localparam int HOLD_W       = 15;
  localparam int DECAY_DIV    = 2;
  localparam int DECAY_STEP   = 16;

  logic       clock;
  logic       reset;
  logic       ready;
  logic [7:0] fv [7];
  logic [2:0] rd_band;
  logic [7:0] rd_level, rd_peak;
  logic       busy, frame_done, overrun;
  logic [1:0] state_dbg;

  spectrum_peak_meter #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .HOLD_W       (HOLD_W),
    .DECAY_DIV    (DECAY_DIV),
    .DECAY_STEP   (DECAY_STEP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .freq1      (fv[0]),
    .freq2      (fv[1]),
    .freq3      (fv[2]),
    .freq4      (fv[3]),
    .freq5      (fv[4]),
    .freq6      (fv[5]),
    .freq7      (fv[6]),
    .rd_band    (rd_band),
    .rd_level   (rd_level),
    .rd_peak    (rd_peak),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // An accepted frame is described by the cycle its sweep starts (s): band k is written in
  // cycle s+k, frame_done shows in cycle s+7, busy spans s..s+7.
  typedef struct {
    int              s;
    logic [6:0][7:0] mag;
    bit              tk;
  } frame_t;

  frame_t sched[$];
  int     cyc, strobes;
  bit     m_ovr;
  int     m_level [7];
  int     m_peak  [7];
  int     m_hold  [7];
  int     n_checks, n_errors;
  int     busy_cnt, done_cnt, last_done;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    sched.delete();
    strobes = 0;
    m_ovr   = 0;
    for (int i = 0; i < 7; i++) begin
      m_level[i] = 0;
      m_peak[i]  = 0;
      m_hold[i]  = 0;
    end
  endtask

  task automatic model_write(input int b, input int n, input bit tk);
    if (n >= m_peak[b]) begin
      m_peak[b] = n;
      m_hold[b] = HOLD_SAMPLES;
    end else if (m_hold[b] != 0) begin
      m_hold[b] = m_hold[b] - 1;
    end else if (tk) begin
      m_peak[b] = (m_peak[b] > DECAY_STEP) ? m_peak[b] - DECAY_STEP : 0;
    end
    m_level[b] = n;
  endtask

  // One clock cycle: compare status for this cycle, feed the model, advance, compare read port.
  task automatic step();
    bit     eb, ed;
    int     el, ep, last_s;
    frame_t fr;
    eb = 0;
    ed = 0;
    foreach (sched[j]) begin
      if (sched[j].s <= cyc && cyc <= sched[j].s + 7) eb = 1;
      if (cyc == sched[j].s + 7) ed = 1;
    end
    check("busy", busy, eb);
    check("frame_done", frame_done, ed);
    check("overrun", overrun, m_ovr);
    if (busy) busy_cnt++;
    if (frame_done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (ready) begin
      strobes++;
      last_s = (sched.size() > 0) ? sched[sched.size()-1].s : -100;
      if (last_s > cyc) begin
        m_ovr = 1;
      end else begin
        fr.s = (last_s + 8 > cyc + 1) ? last_s + 8 : cyc + 1;
        for (int k = 0; k < 7; k++) fr.mag[k] = fv[k];
        fr.tk = ((strobes % DECAY_DIV) == 0);
        sched.push_back(fr);
      end
    end
    el = (rd_band < 7) ? m_level[rd_band] : 0;
    ep = (rd_band < 7) ? m_peak[rd_band]  : 0;
    foreach (sched[j]) begin
      if (sched[j].s <= cyc && cyc <= sched[j].s + 6)
        model_write(cyc - sched[j].s, int'(sched[j].mag[cyc - sched[j].s]), sched[j].tk);
    end
    @(posedge clock);
    #1;
    cyc++;
    check("rd_level", rd_level, el);
    check("rd_peak", rd_peak, ep);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic send_frame(input int b0, input int drain);
    for (int k = 0; k < 7; k++) fv[k] = 8'd0;
    fv[0] = 8'(b0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (drain) step();
  endtask

  task automatic read_band(input int b, output int lvl, output int pk);
    rd_band = 3'(b);
    step();
    lvl = rd_level;
    pk  = rd_peak;
  endtask

  typedef struct {
    logic [2:0] band;
    logic [7:0] level;
    logic [7:0] peak;
  } vec_t;

  vec_t read_tab [8];
  int   exp3 [8];
  int   exp4 [8];

  initial begin
    int a, lvl, pk;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    reset    = 1'b1;
    ready    = 1'b0;
    rd_band  = '0;
    for (int k = 0; k < 7; k++) fv[k] = '0;
    for (int i = 0; i < 7; i++) read_tab[i] = '{3'(i), 8'(10 * (i + 1)), 8'(10 * (i + 1))};
    read_tab[7] = '{3'd7, 8'd0, 8'd0};
    exp3 = '{200, 200, 200, 200, 200, 184, 184, 168};
    exp4 = '{10, 10, 10, 10, 10, 0, 0, 0};
    model_clear();

    // 1: reset state
    do_reset();
    for (int b = 0; b < 8; b++) begin
      read_band(b, lvl, pk);
      check("t1_level", lvl, 0);
      check("t1_peak", pk, 0);
    end
    check("t1_busy", busy, 0);
    check("t1_overrun", overrun, 0);

    // 2: single frame 10..70, latency and read table
    busy_cnt = 0;
    done_cnt = 0;
    a = cyc;
    for (int k = 0; k < 7; k++) fv[k] = 8'(10 * (k + 1));
    ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (12) step();
    check("t2_busy_cycles", busy_cnt, 8);
    check("t2_done_count", done_cnt, 1);
    check("t2_done_cycle", last_done - a, 8);
    for (int i = 0; i < 8; i++) begin
      read_band(read_tab[i].band, lvl, pk);
      check("t2_tab_level", lvl, read_tab[i].level);
      check("t2_tab_peak", pk, read_tab[i].peak);
    end

    // 3: hold then decay by 16 on tick frames
    do_reset();
    for (int f = 0; f < 8; f++) begin
      send_frame((f == 0) ? 200 : 0, 10);
      read_band(0, lvl, pk);
      check("t3_peak", pk, exp3[f]);
      check("t3_level", lvl, (f == 0) ? 200 : 0);
    end

    // 4: decay saturates at zero
    do_reset();
    for (int f = 0; f < 8; f++) begin
      send_frame((f == 0) ? 10 : 0, 10);
      read_band(0, lvl, pk);
      check("t4_peak", pk, exp4[f]);
    end

    // 5: three strobes 2 cycles apart: second pends, third dropped
    do_reset();
    busy_cnt = 0;
    done_cnt = 0;
    a = cyc;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 7; k++) fv[k] = 8'($urandom_range(0, 255));
      ready = 1'b1;
      step();
      ready = 1'b0;
      if (s < 2) step();
    end
    repeat (20) step();
    check("t5_done_count", done_cnt, 2);
    check("t5_second_done", last_done - a, 16);
    check("t5_overrun", overrun, 1);
    send_frame(5, 12);
    check("t5_overrun_sticky", overrun, 1);
    do_reset();
    step();
    check("t5_overrun_cleared", overrun, 0);

    // 6: reset mid-sweep with a frame pending
    do_reset();
    for (int k = 0; k < 7; k++) fv[k] = 8'($urandom_range(1, 255));
    ready = 1'b1;
    step();
    for (int k = 0; k < 7; k++) fv[k] = 8'($urandom_range(1, 255));
    step();
    ready = 1'b0;
    step();
    step();
    check("t6_busy_before", busy, 1);
    do_reset();
    done_cnt = 0;
    check("t6_busy_after", busy, 0);
    for (int b = 0; b < 8; b++) begin
      read_band(b, lvl, pk);
      check("t6_level", lvl, 0);
      check("t6_peak", pk, 0);
    end
    repeat (12) step();
    check("t6_no_done", done_cnt, 0);

    // random traffic: sparse then dense strobes, random reads
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 500; n++) begin
        ready = (phase == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
        for (int k = 0; k < 7; k++)
          fv[k] = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
        rd_band = 3'($urandom_range(0, 7));
        step();
      end
      ready = 1'b0;
      repeat (20) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
